// File: rtl/etapa_if.sv
// Instruction-fetch stage: next-PC selection, req/ack fetch handshake with a one-word skid, IF/ID register.
// Optional fetch/flush performance counters are compiled in with ETAPA_IF_PERF_EN.
module etapa_if #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        MEM_RD_I,
   input  logic [1:0]  SEL_DIR,
   input  logic        resetIF,
   input  logic        stall,
   input  logic [31:0] jr_addr,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_data,
   output logic [31:0] instr,
   output logic [31:0] pc4_out,
   output logic        instr_valid,
   output logic [5:0]  opcode,
`ifdef ETAPA_IF_PERF_EN
   output logic [31:0] fetch_cnt,
   output logic [31:0] flush_cnt,
`endif
   output logic [5:0]  funct
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] addr_q, addr_d;
   logic        req_q, req_d;
   logic        drop_q, drop_d;
   logic [31:0] skid_q, skid_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;

   logic        redirect;
   logic [31:0] target;
   logic        load;
   logic [31:0] load_word;
   state_t      resume_state;

   assign redirect     = (SEL_DIR == 2'b01 || SEL_DIR == 2'b10) && valid_q && !stall;
   assign target       = (SEL_DIR == 2'b01) ? {pc4_q[31:28], instr_q[25:0], 2'b00} : jr_addr;
   assign resume_state = MEM_RD_I ? REQ : IDLE;

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can leave a latch behind.
      state_d   = state_q;
      pc_d      = pc_q;
      drop_d    = drop_q;
      skid_d    = skid_q;
      instr_d   = instr_q;
      pc4_d     = pc4_q;
      valid_d   = valid_q;
      load      = 1'b0;
      load_word = skid_q;

      unique case (state_q)
         IDLE: state_d = resume_state;
         REQ: begin
            if (imem_ack) begin
               if (drop_q) begin
                  drop_d  = 1'b0;
                  state_d = resume_state;
               end else if (redirect) begin
                  state_d = resume_state;
               end else if (stall) begin
                  skid_d  = imem_data;
                  state_d = HOLD;
               end else begin
                  load      = 1'b1;
                  load_word = imem_data;
                  state_d   = resume_state;
               end
            end else if (redirect) begin
               drop_d = 1'b1;
            end
         end
         HOLD: begin
            if (redirect) begin
               state_d = IDLE;
            end else if (!stall) begin
               load    = 1'b1;
               state_d = resume_state;
            end
         end
         default: state_d = IDLE;
      endcase

      if (redirect) begin
         pc_d = target;
      end else if (load) begin
         pc_d = pc_q + 32'd4;
      end

      // A flush wins over both a stall and a word arriving on the same edge.
      if (resetIF) begin
         instr_d = 32'h0;
         pc4_d   = 32'h0;
         valid_d = 1'b0;
      end else if (load) begin
         instr_d = load_word;
         pc4_d   = pc_q + 32'd4;
         valid_d = 1'b1;
      end

      // An un-acked request keeps its address even when the PC is redirected underneath it.
      addr_d = (state_q == REQ && !imem_ack) ? addr_q : pc_d;
      req_d  = (state_d == REQ);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         addr_q  <= RESET_PC;
         req_q   <= 1'b0;
         drop_q  <= 1'b0;
         // NOTE: the skid word is reset too, so a HOLD entered after reset never exposes X.
         skid_q  <= 32'h0;
         instr_q <= 32'h0;
         pc4_q   <= 32'h0;
         valid_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q <= state_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         req_q   <= req_d;
         drop_q  <= drop_d;
         skid_q  <= skid_d;
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
      end
   end

   assign imem_req    = req_q;
   assign imem_addr   = addr_q;
   assign instr       = instr_q;
   assign pc4_out     = pc4_q;
   assign instr_valid = valid_q;
   assign opcode      = instr_q[31:26];
   assign funct       = instr_q[5:0];

`ifdef ETAPA_IF_PERF_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      fetch_cnt_d = fetch_cnt_q + {31'h0, (load && !resetIF)};
      flush_cnt_d = flush_cnt_q + {31'h0, (resetIF || redirect)};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt_q <= 32'h0;
         flush_cnt_q <= 32'h0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign fetch_cnt = fetch_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_etapa_if.sv
// Self-checking bench for etapa_if: directed vector table, hand-written corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_etapa_if;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_rd;
   logic [1:0]  sel_dir;
   logic        reset_if;
   logic        stall;
   logic [31:0] jr_addr;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_data;
   logic [31:0] instr;
   logic [31:0] pc4_out;
   logic        instr_valid;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [31:0] data_xor;
`ifdef ETAPA_IF_PERF_EN
   logic [31:0] fetch_cnt;
   logic [31:0] flush_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   // Memory model: word at an address is the address xor a per-phase pattern.
   assign imem_data = imem_addr ^ data_xor;

   etapa_if #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst_n(rst_n), .MEM_RD_I(mem_rd), .SEL_DIR(sel_dir), .resetIF(reset_if),
      .stall(stall), .jr_addr(jr_addr), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_data(imem_data), .instr(instr), .pc4_out(pc4_out),
      .instr_valid(instr_valid), .opcode(opcode),
`ifdef ETAPA_IF_PERF_EN
      .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt),
`endif
      .funct(funct)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 25) $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic e_req, input logic [31:0] e_addr,
                             input logic [31:0] e_instr, input logic [31:0] e_pc4, input logic e_valid);
      check({tag, " imem_req"}, {31'h0, imem_req}, {31'h0, e_req});
      check({tag, " imem_addr"}, imem_addr, e_addr);
      check({tag, " instr"}, instr, e_instr);
      check({tag, " pc4_out"}, pc4_out, e_pc4);
      check({tag, " instr_valid"}, {31'h0, instr_valid}, {31'h0, e_valid});
      check({tag, " opcode"}, {26'h0, opcode}, {26'h0, e_instr[31:26]});
      check({tag, " funct"}, {26'h0, funct}, {26'h0, e_instr[5:0]});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic rd, input logic ack, input logic stl, input logic rif,
                         input logic [1:0] sel, input logic [31:0] jr);
      mem_rd = rd; imem_ack = ack; stall = stl; reset_if = rif; sel_dir = sel; jr_addr = jr;
   endtask

   task automatic do_reset();
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic        rd, ack, stl, rif;
      logic [1:0]  sel;
      logic [31:0] jr, xr;
      logic        e_req;
      logic [31:0] e_addr, e_instr, e_pc4;
      logic        e_valid;
   } vec_t;

   vec_t vt[$];

   task automatic add(input logic rd, input logic ack, input logic stl, input logic rif,
                      input logic [1:0] sel, input logic [31:0] jr, input logic [31:0] xr,
                      input logic e_req, input logic [31:0] e_addr, input logic [31:0] e_instr,
                      input logic [31:0] e_pc4, input logic e_valid);
      vec_t v;
      v.rd = rd; v.ack = ack; v.stl = stl; v.rif = rif; v.sel = sel; v.jr = jr; v.xr = xr;
      v.e_req = e_req; v.e_addr = e_addr; v.e_instr = e_instr; v.e_pc4 = e_pc4; v.e_valid = e_valid;
      vt.push_back(v);
   endtask

   // Reference model: fetch engine described as outstanding request, optional parked word, IF/ID contents.
   logic        m_busy, m_parked, m_drop, m_valid;
   logic [31:0] m_pc, m_addr, m_park, m_instr, m_pc4;

   task automatic model_reset();
      m_busy = 0; m_parked = 0; m_drop = 0; m_valid = 0;
      m_pc = 0; m_addr = 0; m_park = 0; m_instr = 0; m_pc4 = 0;
   endtask

   task automatic model_step(input logic rd, input logic ack, input logic stl, input logic rif,
                             input logic [1:0] sel, input logic [31:0] jr, input logic [31:0] word_in);
      logic        jump, took, deliver, waiting;
      logic [31:0] dest, word, old_pc;
      jump    = (sel == 2'b01 || sel == 2'b10) && m_valid && !stl;
      dest    = (sel == 2'b01) ? {m_pc4[31:28], m_instr[25:0], 2'b00} : jr;
      took    = m_busy && ack;
      waiting = m_busy && !ack;
      deliver = 0;
      word    = 0;
      old_pc  = m_pc;
      if (m_busy) begin
         if (took) begin
            if (m_drop) begin m_drop = 0; m_busy = rd; end
            else if (jump) m_busy = rd;
            else if (stl) begin m_park = word_in; m_parked = 1; m_busy = 0; end
            else begin deliver = 1; word = word_in; m_busy = rd; end
         end else if (jump) m_drop = 1;
      end else if (m_parked) begin
         if (jump) m_parked = 0;
         else if (!stl) begin deliver = 1; word = m_park; m_parked = 0; m_busy = rd; end
      end else begin
         m_busy = rd;
      end
      if (jump) m_pc = dest;
      else if (deliver) m_pc = old_pc + 4;
      if (rif) begin m_instr = 0; m_pc4 = 0; m_valid = 0; end
      else if (deliver) begin m_instr = word; m_pc4 = old_pc + 4; m_valid = 1; end
      if (!waiting) m_addr = m_pc;
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int budget;
      data_xor = 32'h0;
      rst_n = 1'b0;
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0);
      #12;
      check_outs("reset", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);

      // rd ack stl rif sel jr xr | req addr instr pc4 valid
      add(1,1,0,0,2'b00,32'h0,32'h0,        1,32'h000,32'h000,32'h000,0);
      add(1,1,0,0,2'b00,32'h0,32'h0,        1,32'h004,32'h000,32'h004,1);
      add(1,1,0,0,2'b00,32'h0,32'h0,        1,32'h008,32'h004,32'h008,1);
      add(1,1,0,0,2'b00,32'h0,32'h0,        1,32'h00C,32'h008,32'h00C,1);
      add(1,1,0,0,2'b00,32'h0,32'h0,        1,32'h010,32'h00C,32'h010,1);
      add(1,0,0,0,2'b00,32'h0,32'h0,        1,32'h010,32'h00C,32'h010,1);
      add(1,0,0,0,2'b00,32'h0,32'h0,        1,32'h010,32'h00C,32'h010,1);
      add(1,0,0,0,2'b00,32'h0,32'h0,        1,32'h010,32'h00C,32'h010,1);
      add(1,1,0,0,2'b00,32'h0,32'h0,        1,32'h014,32'h010,32'h014,1);
      add(1,1,1,0,2'b00,32'h0,32'h0,        0,32'h014,32'h010,32'h014,1);
      add(1,0,1,0,2'b00,32'h0,32'h0,        0,32'h014,32'h010,32'h014,1);
      add(1,0,1,0,2'b00,32'h0,32'h0,        0,32'h014,32'h010,32'h014,1);
      add(1,0,0,0,2'b00,32'h0,32'h0,        1,32'h018,32'h014,32'h018,1);
      add(1,1,0,0,2'b00,32'h0,32'h0,        1,32'h01C,32'h018,32'h01C,1);
      add(1,1,0,0,2'b00,32'h0,32'h0,        1,32'h020,32'h01C,32'h020,1);
      add(1,1,0,0,2'b00,32'h0,32'h0800_0030,1,32'h024,32'h0800_0010,32'h024,1);
      add(1,0,0,1,2'b01,32'h0,32'h0,        1,32'h024,32'h000,32'h000,0);
      add(1,1,0,0,2'b00,32'h0,32'h0,        1,32'h040,32'h000,32'h000,0);
      add(1,1,0,0,2'b00,32'h0,32'h0,        1,32'h044,32'h040,32'h044,1);
      add(1,0,0,0,2'b10,32'h100,32'h0,      1,32'h044,32'h040,32'h044,1);
      add(1,0,0,0,2'b00,32'h0,32'h0,        1,32'h044,32'h040,32'h044,1);
      add(1,1,0,0,2'b00,32'h0,32'h0,        1,32'h100,32'h040,32'h044,1);
      add(1,1,0,0,2'b00,32'h0,32'h0,        1,32'h104,32'h100,32'h104,1);
      add(1,1,0,0,2'b01,32'h0,32'h0,        1,32'h400,32'h100,32'h104,1);
      add(1,1,0,0,2'b00,32'h0,32'h0,        1,32'h404,32'h400,32'h404,1);
      add(0,1,0,0,2'b00,32'h0,32'h0,        0,32'h408,32'h404,32'h408,1);
      add(0,0,0,0,2'b00,32'h0,32'h0,        0,32'h408,32'h404,32'h408,1);
      add(1,0,0,0,2'b00,32'h0,32'h0,        1,32'h408,32'h404,32'h408,1);

      @(negedge clk);
      rst_n = 1'b1;
      #4;
      for (int i = 0; i < vt.size(); i++) begin
         set_in(vt[i].rd, vt[i].ack, vt[i].stl, vt[i].rif, vt[i].sel, vt[i].jr);
         data_xor = vt[i].xr;
         tick();
         check_outs($sformatf("vec%0d", i), vt[i].e_req, vt[i].e_addr, vt[i].e_instr,
                    vt[i].e_pc4, vt[i].e_valid);
      end
      data_xor = 32'h0;

      // jr to the top of the address space, then PC+4 wraps to zero.
      set_in(1, 1, 0, 0, 2'b10, 32'hFFFF_FFFC);
      tick();
      check_outs("wrap redirect", 1'b1, 32'hFFFF_FFFC, 32'h404, 32'h408, 1'b1);
      set_in(1, 1, 0, 0, 2'b00, 32'h0);
      tick();
      check_outs("wrap load", 1'b1, 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b1);

      // Redirect while a stalled word is parked: the word is discarded and fetch idles.
      set_in(1, 1, 1, 0, 2'b00, 32'h0);
      tick();
      check_outs("hold enter", 1'b0, 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b1);
      set_in(1, 0, 0, 0, 2'b10, 32'h200);
      tick();
      check("hold redirect req", {31'h0, imem_req}, 32'h0);
      check("hold redirect instr", instr, 32'hFFFF_FFFC);
      set_in(1, 0, 0, 0, 2'b00, 32'h0);
      tick();
      check_outs("hold restart", 1'b1, 32'h200, 32'hFFFF_FFFC, 32'h0, 1'b1);
      set_in(1, 1, 0, 0, 2'b00, 32'h0);
      tick();
      check_outs("hold target load", 1'b1, 32'h204, 32'h200, 32'h204, 1'b1);

      // Asynchronous reset in the middle of an outstanding request at pc 0x20.
      do_reset();
      set_in(1, 1, 0, 0, 2'b00, 32'h0);
      budget = 0;
      while (imem_addr !== 32'h20 && budget < 20) begin
         tick();
         budget++;
      end
      check("reach pc 0x20 within budget", {31'h0, (budget < 20)}, 32'h1);
      imem_ack = 1'b0;
      tick();
      check("mid-req req", {31'h0, imem_req}, 32'h1);
      #2 rst_n = 1'b0;
      #1;
      check_outs("async reset", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      #2 rst_n = 1'b1;
      imem_ack = 1'b1;
      tick();
      check_outs("restart req", 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
      tick();
      check_outs("restart load", 1'b1, 32'h4, 32'h0, 32'h4, 1'b1);

      // Randomized traffic against the reference model.
      do_reset();
      model_reset();
      data_xor = $urandom();
      #4;
      for (int c = 0; c < 3000; c++) begin
         logic [31:0] w;
         set_in(($urandom_range(0, 7) != 0), ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)), $urandom() & 32'hFFFF_FFFC);
         if ($urandom_range(0, 1) == 0) sel_dir = 2'b00;
         w = m_addr ^ data_xor;
         model_step(mem_rd, imem_ack, stall, reset_if, sel_dir, jr_addr, w);
         tick();
         check_outs($sformatf("rand%0d", c), m_busy, m_addr, m_instr, m_pc4, m_valid);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
